// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - FIPS 180-4 message padder feeding 512-bit blocks to the sha256 core
module sha256_padder #(
    parameter int LEN_W = 61
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [511:0]     blk_data,
    output logic             blk_valid,
    input  logic             blk_rdy,
    output logic [63:0]      total_blocks,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, EMIT} state_t;

    state_t           state, state_nxt, ret_state;
    logic [511:0]     blk_buf;
    logic [5:0]       idx;
    logic [8:0]       bit_hi;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] consumed;
    logic             final_blk;
    logic             marker_done;
    logic [63:0]      blk_cnt;
    logic             last_byte;

    assign bit_hi    = 9'd511 - {idx, 3'b000};
    assign last_byte = (consumed + 1'b1) == len_q;
    assign blk_data  = blk_buf;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = (msg_len == '0) ? PAD : FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (idx == 6'd63)   state_nxt = EMIT;
                    else if (last_byte) state_nxt = PAD;
                end
            end
            PAD: begin
                // Length needs bytes 56..63 free; otherwise spill into one more block.
                if (idx == 6'd55)      state_nxt = LEN;
                else if (idx == 6'd63) state_nxt = EMIT;
            end
            LEN: state_nxt = EMIT;
            EMIT: begin
                blk_valid = 1'b1;
                if (blk_rdy) state_nxt = final_blk ? IDLE : ret_state;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ret_state    <= IDLE;
            blk_buf      <= '0;
            idx          <= '0;
            len_q        <= '0;
            consumed     <= '0;
            final_blk    <= 1'b0;
            marker_done  <= 1'b0;
            blk_cnt      <= '0;
            total_blocks <= '0;
            done         <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q        <= msg_len;
                        total_blocks <= ((64'(msg_len) + 64'd8) >> 6) + 64'd1;
                        blk_buf      <= '0;
                        idx          <= '0;
                        consumed     <= '0;
                        final_blk    <= 1'b0;
                        marker_done  <= 1'b0;
                        blk_cnt      <= '0;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        blk_buf[bit_hi -: 8] <= in_data;
                        idx                  <= idx + 6'd1;
                        consumed             <= consumed + 1'b1;
                        if (idx == 6'd63) ret_state <= last_byte ? PAD : FILL;
                    end
                end
                PAD: begin
                    blk_buf[bit_hi -: 8] <= marker_done ? 8'h00 : 8'h80;
                    marker_done          <= 1'b1;
                    idx                  <= idx + 6'd1;
                    if (idx == 6'd63) ret_state <= PAD;
                end
                LEN: begin
                    blk_buf[63:0] <= 64'({len_q, 3'b000});
                    final_blk     <= 1'b1;
                end
                EMIT: begin
                    if (blk_rdy) begin
                        blk_buf <= '0;
                        blk_cnt <= blk_cnt + 64'd1;
                        if (final_blk) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    a_block_count: assert property (@(posedge clk) disable iff (!rst)
        done |-> (blk_cnt == total_blocks));

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - self-checking bench for sha256_padder against a byte-queue padding model
module tb_sha256_padder;
    localparam int LEN_W = 61;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             start    = 1'b0;
    logic [LEN_W-1:0] msg_len  = '0;
    logic [7:0]       in_data  = 8'h00;
    logic             in_valid = 1'b0;
    logic             blk_rdy  = 1'b0;
    logic             in_ready, blk_valid, busy, done;
    logic [511:0]     blk_data;
    logic [63:0]      total_blocks;

    sha256_padder #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_rdy(blk_rdy),
        .total_blocks(total_blocks), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int           checks = 0, errors = 0;
    logic [7:0]   msg [0:255];
    logic [511:0] exp_blk [$];
    logic [511:0] lit_blk [0:3];
    bit           lit_en  [0:3] = '{default: 1'b0};
    int           cur_len = 0, base = 0, acc_base = 0, exp_done = 0, timeouts = 0;
    int           blk_seen = 0, acc_bytes = 0, done_seen = 0, k;
    bit           hold_rdy = 1'b0, finish_req = 1'b0, prev_valid = 1'b0;
    logic [511:0] prev_data;

    // Padding model: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic build_model(input int len);
        logic [7:0]   p [$];
        logic [63:0]  bits;
        logic [511:0] b;
        for (int i = 0; i < len; i++) p.push_back(msg[i]);
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(len) * 64'd8;
        for (int j = 7; j >= 0; j--) p.push_back(bits[8*j +: 8]);
        exp_blk.delete();
        for (int n = 0; n < p.size() / 64; n++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*n+j];
            exp_blk.push_back(b);
        end
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        blk_rdy = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_ctrl", {in_ready, blk_valid, busy, done}, '0);
            chk("reset_blk_data", blk_data, '0);
            chk("reset_total_blocks", total_blocks, '0);
            prev_valid = 1'b0;
        end else begin
            if (blk_valid) begin
                chk("emit_in_ready", in_ready, '0);
                if (prev_valid) chk("emit_stable", blk_data, prev_data);
            end
            prev_valid = blk_valid && !blk_rdy;
            prev_data  = blk_data;
            if (in_valid && in_ready) acc_bytes++;
            if (blk_valid && blk_rdy) begin
                k = blk_seen - base;
                if (k < exp_blk.size()) chk("block", blk_data, exp_blk[k]);
                else                    chk("extra_block", k, exp_blk.size());
                if (k < 4 && lit_en[k]) chk("block_literal", blk_data, lit_blk[k]);
                blk_seen++;
            end
            if (done) begin
                chk("done_block_count", blk_seen - base, exp_blk.size());
                chk("total_blocks", total_blocks, exp_blk.size());
                chk("bytes_consumed", acc_bytes - acc_base, cur_len);
                done_seen++;
            end
        end
        if (finish_req) begin
            chk("done_pulses", done_seen, exp_done);
            chk("timeouts", timeouts, 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic run_msg(input int len, input bit bp);
        int sent, guard, d0;
        bit hs, bp_done;
        build_model(len);
        cur_len  = len;
        base     = blk_seen;
        acc_base = acc_bytes;
        exp_done++;
        d0       = done_seen;
        sent     = 0;
        guard    = 0;
        bp_done  = 1'b0;
        hold_rdy = bp;
        msg_len  = LEN_W'(len);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (sent < len && guard < 5000) begin
            guard++;
            in_data  = msg[sent];
            in_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bp && !bp_done && blk_valid) begin
                bp_done = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk); #1;
                    in_valid = ~in_valid;
                    @(negedge clk);
                end
                hold_rdy = 1'b0;
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) sent++;
        end
        in_valid = 1'b0;
        hold_rdy = 1'b0;
        for (int c = 0; c < 3000 && done_seen == d0; c++) @(posedge clk);
        #1;
        if (done_seen == d0) timeouts++;
        lit_en = '{default: 1'b0};
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        lit_blk[0] = {32'h61626380, 416'h0, 64'h18}; lit_en[0] = 1'b1;
        run_msg(3, 1'b0);

        lit_blk[0] = {8'h80, 504'h0}; lit_en[0] = 1'b1;
        run_msg(0, 1'b0);

        for (int i = 0; i < 55; i++) msg[i] = 8'h00;
        lit_blk[0] = {440'h0, 8'h80, 64'h1B8}; lit_en[0] = 1'b1;
        run_msg(55, 1'b0);

        for (int i = 0; i < 256; i++) msg[i] = 8'(i * 37 + 5);
        lit_blk[1] = {448'h0, 64'h1C0}; lit_en[1] = 1'b1;
        run_msg(56, 1'b0);

        lit_blk[1] = {8'h80, 440'h0, 64'h200}; lit_en[1] = 1'b1;
        run_msg(64, 1'b0);

        run_msg(100, 1'b1);

        for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
        run_msg(119, 1'b0);
        run_msg(120, 1'b0);
        run_msg(128, 1'b0);
        run_msg(200, 1'b0);

        // Abandon a 100-byte message partway through FILL.
        msg_len = LEN_W'(100);
        start   = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        lit_blk[0] = {32'h61626380, 416'h0, 64'h18}; lit_en[0] = 1'b1;
        run_msg(3, 1'b0);

        finish_req = 1'b1;
    end

endmodule
